// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - byte RAM decoding 10-bit SPI slave words into address/data commands
//
// Purpose:
//   Decodes each word delivered by the SPI slave on its parallel receive bus.
//   The word is acted on once, at the first clock edge of an rx_valid assertion.
//   Opcode din[9:8]:
//     00 load write address, 01 write byte, 10 load read address, 11 return byte.
//   Optional feature macro SPI_RAM_AUTOINC_EN: the write address advances after
//   each byte write, and the read address advances after each byte read.
//   Both addresses wrap modulo MEM_DEPTH.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   rst       in   1   asynchronous active-high reset (memory contents not reset)
//   din       in  10   [9:8] opcode, [7:0] payload
//   rx_valid  in   1   word-valid level from the slave
//   dout      out  8   read byte, held until the next read-data accept
//   tx_valid  out  1   dout valid, high until rx_valid is sampled low

module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    logic [7:0]           mem_q [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 rx_valid_dly_q;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 acc;
    logic                 mem_we;

    // Accept only on the rising edge of rx_valid, so a level held for many
    // cycles decodes exactly one word.
    assign acc = rx_valid & ~rx_valid_dly_q;

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        mem_we     = 1'b0;
        if (acc) begin
            case (din[9:8])
                2'b00: wr_addr_d = din[ADDR_SIZE-1:0];
                2'b01: begin
                    mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`endif
                end
                2'b10: rd_addr_d = din[ADDR_SIZE-1:0];
                default: begin
                    dout_d     = mem_q[rd_addr_q];
                    tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
`endif
                end
            endcase
        end
        // Any low sample of rx_valid ends the read transaction; dout is kept.
        if (!rx_valid) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            rx_valid_dly_q <= 1'b0;
            dout_q         <= 8'h00;
            tx_valid_q     <= 1'b0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            rx_valid_dly_q <= rx_valid;
            dout_q         <= dout_d;
            tx_valid_q     <= tx_valid_d;
        end
    end

    // Storage keeps its contents across reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - scoreboard bench for spi_ram against a command-level memory model

module tb_spi_ram;

    localparam int DEPTH = 256;

    logic       clk;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    spi_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       known;
        bit [7:0] data;
        int       len;
    } exp_t;

    exp_t sb[$];

    int vectors;
    int miscompares;

    // Behavioural model: a byte array plus two address pointers.
    bit [7:0] m_mem   [DEPTH];
    bit       m_known [DEPTH];
    int       m_wr;
    int       m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0;
        m_rd = 0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [9:0] w, input int hold);
        exp_t e;
        case (w[9:8])
            2'b00: m_wr = int'(w[7:0]) % DEPTH;
            2'b01: begin
                m_mem[m_wr]   = w[7:0];
                m_known[m_wr] = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                m_wr = (m_wr + 1) % DEPTH;
`endif
            end
            2'b10: m_rd = int'(w[7:0]) % DEPTH;
            default: begin
                e.known = m_known[m_rd];
                e.data  = m_mem[m_rd];
                e.len   = hold;
                sb.push_back(e);
`ifdef SPI_RAM_AUTOINC_EN
                m_rd = (m_rd + 1) % DEPTH;
`endif
            end
        endcase
    endtask

    // Called at posedge+1; rx_valid is sampled high for 'hold' edges, then low for 'gap'.
    task automatic send(input logic [9:0] w, input int hold, input int gap,
                        input int chg_at, input logic [9:0] w2);
        din      = w;
        rx_valid = 1'b1;
        model_accept(w, hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (i + 1 == chg_at) din = w2;
        end
        rx_valid = 1'b0;
        din      = 10'($urandom);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Monitor: every tx_valid pulse must match the next queued read in data,
    // stay stable and last exactly as long as rx_valid was held.
    bit       in_pulse;
    int       plen;
    int       exp_len;
    bit [7:0] pdata;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_pulse = 1'b0;
        end else if (tx_valid && !in_pulse) begin
            in_pulse = 1'b1;
            plen     = 1;
            pdata    = dout;
            exp_len  = -1;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tx_valid: got 1, expected 0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                exp_len = e.len;
                if (e.known) check("read_data", 32'(dout), 32'(e.data));
            end
        end else if (tx_valid && in_pulse) begin
            plen++;
            if (dout !== pdata) check("dout_stable", 32'(dout), 32'(pdata));
        end else if (!tx_valid && in_pulse) begin
            in_pulse = 1'b0;
            if (exp_len >= 0) check("tx_valid_len", 32'(plen), 32'(exp_len));
        end
    end

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    initial begin
        #1_000_000;
        vectors++;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        summary();
        $finish;
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();
        rst      = 1'b0;
        rx_valid = 1'b0;
        din      = 10'h000;
        #1 rst = 1'b1;
        #2;
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic path
        send(10'h03C, 4, 2, -1, 10'h0);
        send(10'h1A5, 4, 2, -1, 10'h0);
        send(10'h23C, 4, 2, -1, 10'h0);
        send(10'h300, 4, 2, -1, 10'h0);

        // Level hold: data change mid-hold must be ignored
        send(10'h010, 2, 1, -1, 10'h0);
        send(10'h15A, 12, 2, 5, 10'h1FF);
        send(10'h133, 3, 1, -1, 10'h0);
        send(10'h210, 2, 1, -1, 10'h0);
        send(10'h300, 3, 2, -1, 10'h0);
        send(10'h211, 2, 1, -1, 10'h0);
        send(10'h300, 3, 2, -1, 10'h0);

        // Address wrap
        send(10'h0FF, 2, 1, -1, 10'h0);
        send(10'h111, 2, 1, -1, 10'h0);
        send(10'h122, 2, 1, -1, 10'h0);
        send(10'h2FF, 2, 1, -1, 10'h0);
        send(10'h300, 2, 2, -1, 10'h0);
        send(10'h300, 2, 2, -1, 10'h0);

        // Back-to-back reads with a single low cycle between
        send(10'h23C, 2, 1, -1, 10'h0);
        din      = 10'h300;
        rx_valid = 1'b1;
        model_accept(10'h300, 3);
        repeat (3) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_low", 32'(tx_valid), 32'h0);
        din      = 10'h300;
        rx_valid = 1'b1;
        model_accept(10'h300, 3);
        @(posedge clk);
        #1;
        check("b2b_high", 32'(tx_valid), 32'h1);
        repeat (2) @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a read, then retention of 0x3C
        send(10'h03C, 2, 1, -1, 10'h0);
        send(10'h1A5, 2, 1, -1, 10'h0);
        send(10'h23C, 2, 1, -1, 10'h0);
        din      = 10'h300;
        rx_valid = 1'b1;
        model_accept(10'h300, 99);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midread_rst_dout", 32'(dout), 32'h00);
        check("midread_rst_tx_valid", 32'(tx_valid), 32'h0);
        rx_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_tx_idle", 32'(tx_valid), 32'h0);
        send(10'h23C, 2, 1, -1, 10'h0);
        send(10'h300, 3, 2, -1, 10'h0);

        // rx_valid already high when reset releases: first cycle is an accept
        rst      = 1'b1;
        din      = 10'h0AA;
        rx_valid = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        model_accept(10'h0AA, 3);
        repeat (3) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
        #1;
        send(10'h177, 2, 1, -1, 10'h0);
        send(10'h2AA, 2, 1, -1, 10'h0);
        send(10'h300, 2, 2, -1, 10'h0);

        // Randomized traffic over a small address window to get frequent hits
        for (int n = 0; n < 200; n++) begin
            logic [9:0] w;
            w[9:8] = 2'($urandom_range(0, 3));
            if (w[9:8] == 2'b01) w[7:0] = 8'($urandom);
            else                 w[7:0] = 8'($urandom_range(0, 15));
            send(w, $urandom_range(1, 5), $urandom_range(1, 3), -1, 10'h0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        summary();
        $finish;
    end

endmodule

// File: doc/spi_ram.md
# spi_ram

Single-port byte RAM that sits directly downstream of the SPI slave. It decodes each 10-bit word the slave delivers on its parallel receive bus: write-address, write-data, read-address or read-data. For read-data it returns a byte together with a valid flag, which the slave shifts out on MISO. The block acts exactly once per receive-valid assertion, however long the slave holds that flag.

## Interface
- `MEM_DEPTH`, default 256: number of byte locations; must equal 2**ADDR_SIZE.
- `ADDR_SIZE`, default 8: address width, 1..8; taken from `din[ADDR_SIZE-1:0]`, upper data bits ignored for addressing.

- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 10: command/payload word from slave; `[9:8]` opcode, `[7:0]` payload.
- `rx_valid` input 1: slave word-valid level; may stay high for many cycles.
- `dout` output 8: read byte to slave transmit path.
- `tx_valid` output 1: `dout` valid; held for the whole read-data transaction.

## Operation
- Internal regs: `wr_addr`, `rd_addr` (ADDR_SIZE each), `rx_valid_d` (1), `mem[MEM_DEPTH]` (8 bits each).
- Accept strobe: `acc = rx_valid & ~rx_valid_d`. `rx_valid_d <= rx_valid` every cycle.
- Opcodes, acted on at the edge where `acc`=1:
  - 00: `wr_addr <= din[ADDR_SIZE-1:0]`.
  - 01: `mem[wr_addr] <= din[7:0]`.
  - 10: `rd_addr <= din[ADDR_SIZE-1:0]`.
  - 11: `dout <= mem[rd_addr]`, `tx_valid <= 1`. `din[7:0]` ignored.
- `tx_valid` clear: at any edge where `rx_valid`=0, `tx_valid <= 0`. `dout` is not cleared and holds until the next opcode-11 accept.
- Edge-only decode: words while `rx_valid` stays high cause no further action, whatever `din` does.
- Read of a never-written location returns uninitialised memory. This is legal; the bench must not check it.
- No opcode checking is needed, because all four encodings are defined.

## Timing
- Reset (async, immediate): `dout`=0, `tx_valid`=0, `wr_addr`=0, `rd_addr`=0, `rx_valid_d`=0. `mem` is not reset and keeps its contents across reset.
- Latency:
  - Write and address loads take effect at the edge where `rx_valid` is first sampled high.
  - `dout` and `tx_valid` are valid one cycle after that edge (registered output).
- `tx_valid` falls on the edge after `rx_valid` is first sampled low.
- `rx_valid` back-to-back (low one cycle, high the next): the low cycle clears `tx_valid`, and the next high is a new accept.
- `rx_valid` already high when `rst` deasserts: `rx_valid_d`=0, so the first post-reset cycle counts as an accept.
- Reset mid-read: `tx_valid` drops asynchronously. After release, it stays 0 until a fresh rising `rx_valid` edge with opcode 11.
- Write then read of the same address uses separate accepts. The read returns the newly written byte, with no bypass needed.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - After an opcode-01 accept, `wr_addr <= wr_addr + 1`, wrapping modulo MEM_DEPTH.
  - After an opcode-11 accept, `rd_addr <= rd_addr + 1`, wrapping.
  - In both cases the pre-increment address is used for the access.
- Undefined: addresses change only on opcodes 00 and 10.

## Test plan
- Reset: drive traffic, assert `rst` mid-cycle → `dout`=0x00 and `tx_valid`=0 with no clock edge. Release, then read address 0x3C (written before reset) via opcodes 10/11 → 0xA5 retained.
- Basic path: `din`=10'h03C, 10'h1A5, 10'h23C, 10'h300, each with `rx_valid` high 4 cycles then low 2 → `dout`=0xA5, `tx_valid`=1 from 1 cycle after the 4th accept edge until 1 cycle after `rx_valid` falls.
- Level hold: write address 0x10, then `din`=10'h15A with `rx_valid` held 12 cycles while `din` changes to 10'h1FF at cycle 5 → `mem[0x10]`=0x5A only. With macro, `wr_addr`=0x11.
- Wrap (macro defined): write address 0xFF, data 0x11, data 0x22; read address 0xFF, read-data twice → 0x11 then 0x22 (address 0x00). Macro undefined: `mem[0xFF]`=0x22, both reads return 0x22.
- Back-to-back: read-data accept, `rx_valid` low exactly 1 cycle, then `din`=10'h300 high → `tx_valid` low for exactly one cycle between, and the second `dout` is correct.
- Post-reset accept: `rx_valid`=1 with `din`=10'h0AA while `rst` deasserts → `wr_addr`=0xAA after the first edge.
